// File: rtl/overcooked_pkg.sv
// Shared player types for the motion controller and the player sprite renderer.
// The renderer decodes player_state with the same pack_state layout.
package overcooked_pkg;

  localparam int unsigned X_W = 11;
  localparam int unsigned Y_W = 10;

  typedef enum logic [1:0] {
    P_LEFT  = 2'd0,
    P_RIGHT = 2'd1,
    P_UP    = 2'd2,
    P_DOWN  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ACT_IDLE  = 2'd0,
    ACT_WALK  = 2'd1,
    ACT_CHOP  = 2'd2,
    ACT_CARRY = 2'd3
  } activity_t;

  function automatic logic [3:0] pack_state(activity_t act, logic [1:0] frame);
    return {act, frame};
  endfunction

endpackage

// File: rtl/vsync_tick.sv
// Frame tick generator: registers active-low vsync and pulses for one cycle on its falling edge.
module vsync_tick (
  input  logic pixel_clk_in,
  input  logic rst_in,
  input  logic vsync_in,
  output logic tick_out
);

  logic cur_q, cur_d;
  logic prev_q, prev_d;

  always_comb begin
    cur_d  = vsync_in;
    prev_d = cur_q;
  end

  // Both stages reset high so a released reset never looks like a falling edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      cur_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      cur_q  <= cur_d;
      prev_q <= prev_d;
    end
  end

  assign tick_out = prev_q & ~cur_q;

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-player motion/activity controller; position, facing and animation state advance once per frame tick.
module player_motion_ctrl
  import overcooked_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned HEIGHT      = 32,
  parameter int unsigned X_INIT      = 64,
  parameter int unsigned Y_INIT      = 64,
  parameter int unsigned X_MAX       = 1024,
  parameter int unsigned Y_MAX       = 768,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned ANIM_DIV    = 8,
  parameter int unsigned CHOP_FRAMES = 32
) (
  input  logic             pixel_clk_in,
  input  logic             rst_in,
  input  logic             vsync_in,
  input  logic [3:0]       dir_btn_in,
  input  logic [3:0]       blocked_in,
  input  logic             action_in,
  input  logic             holding_in,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic [1:0]       player_direction,
  output logic [3:0]       player_state,
  output logic             frame_tick_out
);

  localparam int unsigned AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int unsigned CW = (CHOP_FRAMES > 1) ? $clog2(CHOP_FRAMES) : 1;

  localparam logic [11:0]    SPD       = 12'(SPEED);
  localparam logic [11:0]    X_HI      = 12'(X_MAX - WIDTH);
  localparam logic [11:0]    Y_HI      = 12'(Y_MAX - HEIGHT);
  localparam logic [X_W-1:0] X_RST     = X_W'(X_INIT);
  localparam logic [Y_W-1:0] Y_RST     = Y_W'(Y_INIT);
  localparam logic [AW-1:0]  ANIM_LAST = AW'(ANIM_DIV - 1);
  localparam logic [CW-1:0]  CHOP_LAST = CW'(CHOP_FRAMES - 1);

  logic tick;

  vsync_tick u_vsync_tick (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .vsync_in     (vsync_in),
    .tick_out     (tick)
  );

  activity_t      act_q, act_d;
  dir_t           dir_q, dir_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [1:0]     frame_q, frame_d;
  logic [AW-1:0]  anim_cnt_q, anim_cnt_d;
  logic [CW-1:0]  chop_cnt_q, chop_cnt_d;
  logic           frame_tick_q, frame_tick_d;

  dir_t           sel_dir;
  logic           btn_any;
  logic           moving;
  logic [11:0]    x_ext, y_ext;
  logic [X_W-1:0] x_dec, x_inc;
  logic [Y_W-1:0] y_dec, y_inc;
  logic           anim_wrap;
  logic [AW-1:0]  anim_adv;
  logic [1:0]     frame_adv;

  always_comb begin
    sel_dir = P_DOWN;
    if (dir_btn_in[0])      sel_dir = P_LEFT;
    else if (dir_btn_in[1]) sel_dir = P_RIGHT;
    else if (dir_btn_in[2]) sel_dir = P_UP;
  end

  assign btn_any = |dir_btn_in;
  assign moving  = btn_any & ~blocked_in[sel_dir];

  // Widened to 12 bits so a step below zero is caught instead of wrapping.
  assign x_ext = {1'b0, x_q};
  assign y_ext = {2'b00, y_q};
  assign x_dec = (x_ext < SPD) ? '0 : X_W'(x_ext - SPD);
  assign x_inc = (x_ext + SPD > X_HI) ? X_W'(X_HI) : X_W'(x_ext + SPD);
  assign y_dec = (y_ext < SPD) ? '0 : Y_W'(y_ext - SPD);
  assign y_inc = (y_ext + SPD > Y_HI) ? Y_W'(Y_HI) : Y_W'(y_ext + SPD);

  assign anim_wrap = (anim_cnt_q == ANIM_LAST);
  assign anim_adv  = anim_wrap ? '0 : anim_cnt_q + AW'(1);
  assign frame_adv = anim_wrap ? frame_q + 2'd1 : frame_q;

  // NOTE: every _d gets a default before the branches, so no path can infer a latch.
  always_comb begin
    act_d        = act_q;
    dir_d        = dir_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_d      = frame_q;
    anim_cnt_d   = anim_cnt_q;
    chop_cnt_d   = chop_cnt_q;
    frame_tick_d = tick;

    if (tick) begin
      case (act_q)
        ACT_CHOP: begin
          if (chop_cnt_q == CHOP_LAST) begin
            act_d      = ACT_IDLE;
            chop_cnt_d = '0;
            anim_cnt_d = '0;
            frame_d    = 2'd0;
          end else begin
            chop_cnt_d = chop_cnt_q + CW'(1);
            anim_cnt_d = anim_adv;
            frame_d    = frame_adv;
          end
        end
        default: begin
          // IDLE, WALK and CARRY share this branch; the wall check only gates motion, not facing.
          if (btn_any) dir_d = sel_dir;
          if (action_in && !holding_in) begin
            act_d      = ACT_CHOP;
            chop_cnt_d = '0;
            anim_cnt_d = '0;
            frame_d    = 2'd0;
          end else begin
            if (holding_in)   act_d = ACT_CARRY;
            else if (btn_any) act_d = ACT_WALK;
            else              act_d = ACT_IDLE;

            if (moving) begin
              case (sel_dir)
                P_LEFT:  x_d = x_dec;
                P_RIGHT: x_d = x_inc;
                P_UP:    y_d = y_dec;
                default: y_d = y_inc;
              endcase
            end

            if (act_d != act_q) begin
              anim_cnt_d = '0;
              frame_d    = 2'd0;
            end else if (moving) begin
              anim_cnt_d = anim_adv;
              frame_d    = frame_adv;
            end else if (act_d != ACT_WALK) begin
              anim_cnt_d = '0;
              frame_d    = 2'd0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      act_q        <= ACT_IDLE;
      dir_q        <= P_DOWN;
      x_q          <= X_RST;
      y_q          <= Y_RST;
      frame_q      <= 2'd0;
      anim_cnt_q   <= '0;
      chop_cnt_q   <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      act_q        <= act_d;
      dir_q        <= dir_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_q      <= frame_d;
      anim_cnt_q   <= anim_cnt_d;
      chop_cnt_q   <= chop_cnt_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign x_out            = x_q;
  assign y_out            = y_q;
  assign player_direction = dir_q;
  assign player_state     = pack_state(act_q, frame_q);
  assign frame_tick_out   = frame_tick_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: a vector table plus hand sequences for latency, clamping,
// the CHOP window and asynchronous reset.
module tb_player_motion_ctrl;
  import overcooked_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic [3:0]  btn;
  logic [3:0]  blk;
  logic        action;
  logic        holding;
  logic [10:0] x;
  logic [9:0]  y;
  logic [1:0]  dir;
  logic [3:0]  st;
  logic        ft;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] blk;
    logic       action;
    logic       holding;
    int         x;
    int         y;
    int         dir;
    int         st;
  } vec_t;

  vec_t vecs[13];

  player_motion_ctrl dut (
    .pixel_clk_in     (clk),
    .rst_in           (rst),
    .vsync_in         (vsync),
    .dir_btn_in       (btn),
    .blocked_in       (blk),
    .action_in        (action),
    .holding_in       (holding),
    .x_out            (x),
    .y_out            (y),
    .player_direction (dir),
    .player_state     (st),
    .frame_tick_out   (ft)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_outs(input string name, input int ex, input int ey, input int ed, input int es);
    check({name, ".x"}, 32'(x), ex);
    check({name, ".y"}, 32'(y), ey);
    check({name, ".dir"}, 32'(dir), ed);
    check({name, ".state"}, 32'(st), es);
  endtask

  task automatic set_in(input logic [3:0] b, input logic [3:0] k, input logic a, input logic h);
    btn = b; blk = k; action = a; holding = h;
  endtask

  // One video frame: pull vsync low, wait (bounded) for the output tick, then restore vsync.
  task automatic frame();
    logic seen;
    seen = 1'b0;
    @(negedge clk) vsync = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(posedge clk); #1;
      if (ft) seen = 1'b1;
    end
    check("tick_seen", 32'(seen), 1);
    @(negedge clk) vsync = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    set_in(4'b0000, 4'b0000, 1'b0, 1'b0);
    vsync = 1'b1;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Mobile-state vectors applied back to back after a fresh reset (x=64, y=64, facing DOWN, IDLE).
    vecs[0]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 64, 64, 3, 4'h0};
    vecs[1]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 64, 64, 3, 4'h0};
    vecs[2]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 64, 64, 3, 4'h0};
    vecs[3]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 64, 62, 2, 4'h4};
    vecs[4]  = '{4'b1101, 4'b0000, 1'b0, 1'b0, 62, 62, 0, 4'h4};
    vecs[5]  = '{4'b0001, 4'b0001, 1'b0, 1'b0, 62, 62, 0, 4'h4};
    vecs[6]  = '{4'b0010, 4'b0000, 1'b0, 1'b0, 64, 62, 1, 4'h4};
    vecs[7]  = '{4'b1000, 4'b0000, 1'b0, 1'b0, 64, 64, 3, 4'h4};
    vecs[8]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 64, 64, 3, 4'h0};
    vecs[9]  = '{4'b0000, 4'b0000, 1'b1, 1'b1, 64, 64, 3, 4'hC};
    vecs[10] = '{4'b0010, 4'b0000, 1'b0, 1'b1, 66, 64, 1, 4'hC};
    vecs[11] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 66, 64, 1, 4'h0};
    vecs[12] = '{4'b0010, 4'b0010, 1'b0, 1'b0, 66, 64, 1, 4'h4};

    // Reset state, including a vsync fall while reset is held that must not tick.
    set_in(4'b0000, 4'b0000, 1'b0, 1'b0);
    vsync = 1'b1;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("tick_in_reset", 32'(ft), 0);
    end
    @(negedge clk) vsync = 1'b1;
    check_outs("reset", 64, 64, 3, 4'h0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("tick_after_release", 32'(ft), 0);
    end

    // Vector table.
    @(negedge clk);
    foreach (vecs[i]) begin
      set_in(vecs[i].btn, vecs[i].blk, vecs[i].action, vecs[i].holding);
      frame();
      check_outs($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].dir, vecs[i].st);
    end

    // Latency: outputs and the tick appear one cycle after the registered fall, for one cycle only.
    do_reset();
    set_in(4'b0001, 4'b0000, 1'b0, 1'b0);
    @(negedge clk) vsync = 1'b0;
    @(posedge clk); #1;
    check("lat_sample.tick", 32'(ft), 0);
    check("lat_sample.x", 32'(x), 64);
    @(posedge clk); #1;
    check("lat_update.tick", 32'(ft), 1);
    check("lat_update.x", 32'(x), 62);
    @(posedge clk); #1;
    check("lat_after.tick", 32'(ft), 0);
    check("lat_after.x", 32'(x), 62);
    @(negedge clk) vsync = 1'b1;
    repeat (2) @(negedge clk);

    // Left walk: the ninth tick is the first animation-frame advance.
    for (int k = 2; k <= 10; k++) begin
      frame();
      check_outs($sformatf("walk_left%0d", k), 64 - 2 * k, 64, 0, (k >= 9) ? 4'h5 : 4'h4);
    end

    // Keep walking left: x clamps at 0 and must never wrap.
    for (int k = 11; k <= 40; k++) begin
      frame();
      check($sformatf("clamp_left%0d", k), 32'(x), (64 - 2 * k < 0) ? 0 : 64 - 2 * k);
    end

    // Walk right from 0 up to 990, then two more ticks clamp at X_MAX-WIDTH = 992.
    set_in(4'b0010, 4'b0000, 1'b0, 1'b0);
    for (int k = 1; k <= 495; k++) frame();
    check_outs("right_990", 990, 64, 1, st[3:2] == 2'd1 ? 32'(st) : 4'h4);
    frame();
    check("right_992a", 32'(x), 992);
    frame();
    check("right_992b", 32'(x), 992);

    // CHOP window: one-tick request, 32 ticks of CHOP with buttons ignored, then IDLE.
    do_reset();
    set_in(4'b0000, 4'b0000, 1'b1, 1'b0);
    frame();
    check_outs("chop_enter", 64, 64, 3, 4'h8);
    set_in(4'b0001, 4'b0000, 1'b0, 1'b0);
    for (int k = 1; k <= 31; k++) begin
      frame();
      check_outs($sformatf("chop%0d", k), 64, 64, 3, {2'b10, 2'(k / 8)});
    end
    frame();
    check_outs("chop_exit", 64, 64, 3, 4'h0);
    frame();
    check_outs("chop_then_walk", 62, 64, 0, 4'h4);

    // Asynchronous reset in the middle of a CHOP, between clock edges.
    set_in(4'b0000, 4'b0000, 1'b1, 1'b0);
    frame();
    check_outs("chop2_enter", 62, 64, 0, 4'h8);
    set_in(4'b0000, 4'b0000, 1'b0, 1'b0);
    repeat (3) frame();
    check_outs("chop2_mid", 62, 64, 0, 4'h8);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_outs("async_rst", 64, 64, 3, 4'h0);
    check("async_rst.tick", 32'(ft), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("tick_after_rst2", 32'(ft), 0);
    end
    @(negedge clk);
    frame();
    check_outs("post_rst_idle", 64, 64, 3, 4'h0);
    set_in(4'b0001, 4'b0000, 1'b0, 1'b0);
    frame();
    check_outs("post_rst_walk", 62, 64, 0, 4'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
